// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: oversamples sclk/sdata on the system clock and rebuilds
// START/addr/GAP1/data/GAP2/STOP frames into parallel words with valid/error strobes.
module serial_frame_receiver #(
  parameter int A_WIDTH     = 7,
  parameter int D_WIDTH     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sclk_in,
  input  logic               sdata_in,
  input  logic               rx_en,
  output logic [A_WIDTH-1:0] a_out,
  output logic [D_WIDTH-1:0] d_out,
  output logic               frame_valid,
  output logic               frame_err,
  output logic               busy
);

  localparam int MAXW = (A_WIDTH > D_WIDTH) ? A_WIDTH : D_WIDTH;
  localparam int BW   = $clog2(MAXW + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] A_LAST = BW'(A_WIDTH - 1);
  localparam logic [BW-1:0] D_LAST = BW'(D_WIDTH - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, GAP1, DATA, GAP2, STOP} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic                   sclk_prev;
  logic                   edge_evt;
  logic                   sample;

  state_t             state;
  logic [BW-1:0]      bit_cnt;
  logic [TW-1:0]      tmo_cnt;
  logic [A_WIDTH-1:0] a_sr;
  logic [D_WIDTH-1:0] d_sr;

  // Synchronizer stage: both lines share the same depth so sample and edge stay aligned.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync  <= '1;
      sdata_sync <= '1;
      sclk_prev  <= 1'b1;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], sdata_in};
      sclk_prev  <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign edge_evt = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign sample   = sdata_sync[SYNC_STAGES-1];

  // Frame stage: tmo_cnt holds cycles elapsed since the last edge while a frame is open.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      a_sr        <= '0;
      d_sr        <= '0;
      a_out       <= '0;
      d_out       <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (!rx_en) begin
        state   <= IDLE;
        busy    <= 1'b0;
        bit_cnt <= '0;
        tmo_cnt <= '0;
      end else if (state != IDLE && !edge_evt && tmo_cnt == T_LAST) begin
        frame_err <= 1'b1;
        state     <= IDLE;
        busy      <= 1'b0;
        bit_cnt   <= '0;
        tmo_cnt   <= '0;
      end else begin
        if (state != IDLE)
          tmo_cnt <= edge_evt ? TW'(1) : tmo_cnt + 1'b1;
        if (edge_evt) begin
          case (state)
            IDLE: begin
              if (!sample) begin
                state   <= ADDR;
                busy    <= 1'b1;
                bit_cnt <= '0;
                tmo_cnt <= TW'(1);
              end
            end
            ADDR: begin
              a_sr <= {a_sr[A_WIDTH-2:0], sample};
              if (bit_cnt == A_LAST) begin
                state   <= GAP1;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            GAP1: state <= DATA;
            DATA: begin
              d_sr <= {d_sr[D_WIDTH-2:0], sample};
              if (bit_cnt == D_LAST) begin
                state   <= GAP2;
                bit_cnt <= '0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            GAP2: state <= STOP;
            STOP: begin
              state   <= IDLE;
              busy    <= 1'b0;
              tmo_cnt <= '0;
              if (!sample) begin
                a_out       <= a_sr;
                d_out       <= d_sr;
                frame_valid <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end
            default: begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Bench for serial_frame_receiver: directed frames plus randomized frames checked
// against a frame-level reference model (expected word and strobe counts).
module tb_serial_frame_receiver;

  localparam int A_WIDTH     = 7;
  localparam int D_WIDTH     = 8;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 64;

  logic               clk;
  logic               reset_n;
  logic               sclk_in;
  logic               sdata_in;
  logic               rx_en;
  logic [A_WIDTH-1:0] a_out;
  logic [D_WIDTH-1:0] d_out;
  logic               frame_valid;
  logic               frame_err;
  logic               busy;

  serial_frame_receiver #(
    .A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sclk_in(sclk_in), .sdata_in(sdata_in), .rx_en(rx_en),
    .a_out(a_out), .d_out(d_out), .frame_valid(frame_valid), .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int vcnt     = 0;
  int ecnt     = 0;
  int both_cnt = 0;
  int valid_cyc = 0;
  int err_cyc   = 0;
  int last_rise = 0;

  // Reference model: expected held word and expected strobe totals.
  logic [A_WIDTH-1:0] exp_a = '0;
  logic [D_WIDTH-1:0] exp_d = '0;
  int exp_vcnt = 0;
  int exp_ecnt = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (frame_valid) begin vcnt++; valid_cyc = cyc; end
    if (frame_err)   begin ecnt++; err_cyc = cyc; end
    if (frame_valid && frame_err) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; each slot drops sclk with new data, then raises it.
  task automatic send_slots(input logic [18:0] bits, input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      sclk_in  = 1'b0;
      sdata_in = bits[18-i];
      repeat (lo) @(negedge clk);
      sclk_in   = 1'b1;
      last_rise = cyc;
      repeat (hi) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [6:0] a, input logic [7:0] d, input logic g1,
                            input logic g2, input logic stop, input int hi, input int lo);
    logic [18:0] bits;
    bits = {1'b0, a, g1, d, g2, stop};
    send_slots(bits, 19, hi, lo);
    if (!stop) begin
      exp_a = a;
      exp_d = d;
      exp_vcnt++;
    end else begin
      exp_ecnt++;
    end
  endtask

  task automatic check_frame(input string tag);
    repeat (SYNC_STAGES + 3) @(negedge clk);
    check({tag, "_valid_cnt"}, vcnt, exp_vcnt);
    check({tag, "_err_cnt"}, ecnt, exp_ecnt);
    check({tag, "_a"}, a_out, exp_a);
    check({tag, "_d"}, d_out, exp_d);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [18:0] part;
    int v0, e0;
    reset_n  = 1'b0;
    sclk_in  = 1'b1;
    sdata_in = 1'b1;
    rx_en    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a", a_out, 0);
    check("rst_d", d_out, 0);
    check("rst_valid", frame_valid, 0);
    check("rst_err", frame_err, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic frame plus output latency from the stop-bit pin edge.
    send_frame(7'b1000001, 8'b10000001, 1'b1, 1'b1, 1'b0, 2, 2);
    check_frame("basic");
    check("valid_latency", valid_cyc - last_rise, SYNC_STAGES + 1);

    // All-ones then back-to-back all-zeros frame.
    send_frame(7'h7F, 8'hFF, 1'b1, 1'b1, 1'b0, 2, 2);
    check_frame("ones");
    send_frame(7'h7F, 8'hFF, 1'b1, 1'b1, 1'b0, 2, 2);
    send_frame(7'h00, 8'h00, 1'b1, 1'b1, 1'b0, 2, 2);
    check_frame("b2b");

    // Bad stop bit, then recovery.
    send_frame(7'h2A, 8'h55, 1'b1, 1'b1, 1'b1, 3, 2);
    check_frame("badstop");
    send_frame(7'h01, 8'h02, 1'b0, 1'b0, 1'b0, 2, 3);
    check_frame("after_bad");

    // Stall after START + 5 address bits.
    part = {1'b0, 7'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    e0 = ecnt;
    send_slots(part, 6, 1, 2);
    repeat (69) @(negedge clk);
    check("tmo_err_cnt", ecnt - e0, 1);
    check("tmo_err_cycle", err_cyc - last_rise, SYNC_STAGES + TIMEOUT);
    check("tmo_busy", busy, 0);
    exp_ecnt++;
    send_frame(7'h33, 8'hCC, 1'b1, 1'b1, 1'b0, 2, 2);
    check_frame("after_tmo");

    // Disable mid-DATA.
    part = {1'b0, 7'h6B, 1'b1, 8'hF0, 1'b1, 1'b0};
    v0 = vcnt; e0 = ecnt;
    send_slots(part, 12, 2, 2);
    rx_en = 1'b0;
    @(negedge clk);
    check("dis_busy", busy, 0);
    send_slots(part, 19, 2, 2);
    repeat (5) @(negedge clk);
    check("dis_no_valid", vcnt - v0, 0);
    check("dis_no_err", ecnt - e0, 0);
    check("dis_a_hold", a_out, exp_a);
    check("dis_d_hold", d_out, exp_d);
    rx_en = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(7'h10, 8'hA5, 1'b1, 1'b1, 1'b0, 2, 2);
    check_frame("reenable");

    // Asynchronous reset mid-frame.
    part = {1'b0, 7'h22, 1'b1, 8'h99, 1'b1, 1'b0};
    send_slots(part, 10, 2, 2);
    #2 reset_n = 1'b0;
    #1;
    check("arst_a", a_out, 0);
    check("arst_d", d_out, 0);
    check("arst_busy", busy, 0);
    exp_a = '0;
    exp_d = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(7'h41, 8'h81, 1'b1, 1'b1, 1'b0, 2, 2);
    check_frame("after_arst");

    // Randomized frames: random word, gaps, phases, occasional bad stop.
    for (int k = 0; k < 16; k++) begin
      send_frame(7'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), $urandom_range(2, 4), $urandom_range(2, 4));
      if ($urandom_range(0, 1) == 1) check_frame("rand");
    end
    check_frame("rand_end");
    check("never_both", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
